// File: rtl/cipher_syndrome.sv
// -----------------------------------------------------------------------------
// cipher_syndrome
//
// Receiver-side syndrome engine for the code-based PKC datapath. A K-bit
// ciphertext is captured on an accepted start. The R x K parity-check matrix H
// then streams in one row per valid/ready beat. Each beat produces one GF(2)
// syndrome bit s[i] = XOR_j (H[i][j] AND c[j]).
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; overrides everything
//   start          begin a new computation (accepted in IDLE or DONE)
//   cipher [K]     ciphertext, sampled only when start is accepted
//   row_valid      row_data carries a valid H row
//   row_data [K]   one H row; bit j multiplies cipher bit j
//   row_ready      a row is consumed this cycle when row_valid is also high
//   syndrome [R]   syndrome, bit i from the i-th streamed row
//   syndrome_valid syndrome / zero_syndrome are final (level)
//   zero_syndrome  all syndrome bits zero (meaningful with syndrome_valid)
//   done           one-cycle pulse when the last row has been absorbed
//   busy           accumulation in progress
// -----------------------------------------------------------------------------
module cipher_syndrome #(
  parameter int q    = 199,
  parameter int t    = 100,
  parameter int n    = q * q,
  parameter int R    = 2 * t * q,
  parameter int K    = n + R,
  parameter int logR = $clog2(R + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] cipher,
  input  logic         row_valid,
  input  logic [K-1:0] row_data,
  output logic         row_ready,
  output logic [R-1:0] syndrome,
  output logic         syndrome_valid,
  output logic         zero_syndrome,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [K-1:0]    cipher_r;
  logic [logR-1:0] cnt_r;
  logic            nz_r;

  logic            row_bit_s;
  logic            last_beat_s;

  // GF(2) inner product: AND is the multiply, XOR-reduction is the sum.
  function automatic logic gf2_dot(input logic [K-1:0] a, input logic [K-1:0] b);
    gf2_dot = ^(a & b);
  endfunction

  // Syndrome bit of the row currently offered, and the final-row indicator.
  always_comb begin
    row_bit_s   = gf2_dot(row_data, cipher_r);
    last_beat_s = (cnt_r == logR'(R - 1));
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      cipher_r       <= '0;
      cnt_r          <= '0;
      nz_r           <= 1'b0;
      syndrome       <= '0;
      syndrome_valid <= 1'b0;
      zero_syndrome  <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
      row_ready      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            cipher_r       <= cipher;
            cnt_r          <= '0;
            nz_r           <= 1'b0;
            syndrome       <= '0;
            syndrome_valid <= 1'b0;
            zero_syndrome  <= 1'b0;
            busy           <= 1'b1;
            row_ready      <= 1'b1;
            state_r        <= ACC;
          end
        end
        ACC: begin
          // start is deliberately ignored here; only row beats advance.
          if (row_valid) begin
            // The syndrome is cleared on start and each position is written
            // exactly once, so OR-ing in a shifted bit equals a write to
            // syndrome[cnt_r]. This avoids an over-wide index on the vector.
            syndrome <= syndrome | (R'(row_bit_s) << cnt_r);
            nz_r     <= nz_r | row_bit_s;
            cnt_r    <= cnt_r + logR'(1);
            if (last_beat_s) begin
              state_r        <= DONE;
              busy           <= 1'b0;
              row_ready      <= 1'b0;
              syndrome_valid <= 1'b1;
              zero_syndrome  <= ~(nz_r | row_bit_s);
              done           <= 1'b1;
            end
          end
        end
        default: begin
          state_r        <= IDLE;
          busy           <= 1'b0;
          row_ready      <= 1'b0;
          syndrome_valid <= 1'b0;
          zero_syndrome  <= 1'b0;
        end
      endcase
    end
  end

endmodule
